// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_pkg
// Purpose  : Shared widths, sequencer state encoding and circular-index
//            helpers for the FIR tap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package dsp_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int AW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_e;

  // (a - b) mod n for 0 <= a,b < n; n need not be a power of two
  function automatic int idx_sub(input int a, input int b, input int n);
    return (a >= b) ? (a - b) : (a + n - b);
  endfunction

  // (a + 1) mod n for 0 <= a < n
  function automatic int idx_inc(input int a, input int n);
    return (a == n - 1) ? 0 : (a + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : fir_delay_line
// Purpose  : Circular sample buffer of NTAPS entries. One write port; the
//            read port returns the sample 'offset' positions older than the
//            entry at 'newest'.
// Revision : 1.0 - initial release
// ============================================================================
module fir_delay_line
  import dsp_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(NTAPS)-1:0] waddr_i,
  input  logic signed [DW-1:0]     wdata_i,
  input  logic [$clog2(NTAPS)-1:0] newest_i,
  input  logic [$clog2(NTAPS)-1:0] offset_i,
  output logic signed [DW-1:0]     rdata_o
);

  localparam int PW = $clog2(NTAPS);

  logic signed [DW-1:0] line_q [NTAPS];
  logic [PW-1:0]        rd_idx;

  // Sample storage: cleared on reset, one entry written per accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        line_q[i] <= '0;
      end
    end else if (we_i) begin
      line_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_idx  = PW'(idx_sub(int'(newest_i), int'(offset_i), NTAPS));
  assign rdata_o = line_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_sequencer
// Purpose  : Drives an external single-cycle MAC as an NTAPS-tap direct-form
//            FIR. Accepts a sample, walks one tap per cycle while feeding the
//            MAC output back as the running sum, then presents the result on
//            a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module fir_tap_sequencer
  import dsp_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DW-1:0]     s_data,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic signed [DW-1:0]     coef_wdata,
  output logic signed [DW-1:0]     mac_a,
  output logic signed [DW-1:0]     mac_b,
  output logic signed [AW-1:0]     mac_acc_in,
  output logic                     mac_en,
  input  logic signed [AW-1:0]     mac_acc_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [AW-1:0]     m_data
);

  localparam int            PW       = $clog2(NTAPS);
  localparam logic [PW-1:0] LAST_TAP = PW'(NTAPS - 1);

  seq_state_e           state_q, state_d;
  logic [PW-1:0]        tap_q, tap_d;
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        newest_q;
  logic signed [DW-1:0] coef_q [NTAPS];
  logic signed [AW-1:0] m_data_q;
  logic                 line_we;
  logic signed [DW-1:0] line_rdata;

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_line (
    .clk      (clk),
    .rst      (rst),
    .we_i     (line_we),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (s_data),
    .newest_i (newest_q),
    .offset_i (tap_q),
    .rdata_o  (line_rdata)
  );

  // State and tap counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  // Next state, tap advance and all handshake/MAC outputs
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    mac_en     = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    mac_acc_in = '0;
    line_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          line_we = 1'b1;
          tap_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mac_en     = 1'b1;
        mac_a      = line_rdata;
        mac_b      = coef_q[tap_q];
        // First tap starts a fresh sum; later taps chain the MAC's registered result
        mac_acc_in = (tap_q == '0) ? '0 : mac_acc_out;
        if (tap_q == LAST_TAP) begin
          state_d = ST_DRAIN;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write pointer and newest-sample index, advanced on each accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      newest_q <= '0;
    end else if (line_we) begin
      newest_q <= wr_ptr_q;
      wr_ptr_q <= PW'(idx_inc(int'(wr_ptr_q), NTAPS));
    end
  end

  // Coefficient bank: writable only while idle and with an in-range index
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_we && (state_q == ST_IDLE) && (int'(coef_addr) < NTAPS)) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  // Result capture once the MAC holds the final sum
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q <= '0;
    end else if (state_q == ST_DRAIN) begin
      m_data_q <= mac_acc_out;
    end
  end

  assign m_data = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fir_tap_sequencer
// Purpose  : Self-checking bench for fir_tap_sequencer with a behavioural
//            MAC and a sum-of-products reference filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_tap_sequencer;

  localparam int NTAPS = 8;
  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int AB    = $clog2(NTAPS);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_data = '0;
  logic                 coef_we = 1'b0;
  logic [AB-1:0]        coef_addr = '0;
  logic signed [DW-1:0] coef_wdata = '0;
  logic signed [DW-1:0] mac_a, mac_b;
  logic signed [AW-1:0] mac_acc_in;
  logic                 mac_en;
  logic signed [AW-1:0] mac_acc_out;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic signed [AW-1:0] m_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_tap_sequencer #(.NTAPS(NTAPS), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_acc_in  (mac_acc_in),
    .mac_en      (mac_en),
    .mac_acc_out (mac_acc_out),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data)
  );

  // Behavioural MAC: registered acc_in + a*b, wrapping at AW bits
  logic signed [AW-1:0] mac_a_x, mac_b_x;
  assign mac_a_x = mac_a;
  assign mac_b_x = mac_b;
  always @(posedge clk) begin
    if (rst)         mac_acc_out <= '0;
    else if (mac_en) mac_acc_out <= mac_acc_in + mac_a_x * mac_b_x;
  end

  // Reference filter: y[n] = sum_k coef[k] * x[n-k], history starts at zero
  logic signed [DW-1:0] ref_coef [NTAPS];
  logic signed [DW-1:0] ref_hist [NTAPS];

  function automatic void ref_clear();
    for (int i = 0; i < NTAPS; i++) begin
      ref_coef[i] = '0;
      ref_hist[i] = '0;
    end
  endfunction

  function automatic logic [AW-1:0] ref_push(input logic signed [DW-1:0] x);
    longint acc = 0;
    for (int i = NTAPS - 1; i > 0; i--) ref_hist[i] = ref_hist[i-1];
    ref_hist[0] = x;
    for (int k = 0; k < NTAPS; k++) acc += longint'(ref_coef[k]) * longint'(ref_hist[k]);
    return acc[AW-1:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0; coef_we = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_clear();
  endtask

  task automatic write_coef(input int addr, input logic signed [DW-1:0] val);
    coef_we = 1'b1; coef_addr = AB'(addr); coef_wdata = val;
    @(negedge clk);
    coef_we = 1'b0;
    ref_coef[addr] = val;
  endtask

  // Drive one sample through; called and returns at a falling edge.
  // lat counts cycles from the accept cycle to the first cycle m_valid is seen.
  task automatic send(input logic signed [DW-1:0] x, input int bp,
                      input bit cw, input int ca, input logic signed [DW-1:0] cd,
                      input bit cw_busy,
                      output logic [AW-1:0] y, output int lat, output int acc_cyc,
                      output bit stable, output bit ok);
    int k;
    ok = 1'b1; stable = 1'b1; y = '0; lat = 0; acc_cyc = 0;
    s_valid = 1'b1; s_data = x;
    coef_we = cw; coef_addr = AB'(ca); coef_wdata = cd;
    k = 0;
    while (!s_ready && k < 50) begin @(negedge clk); k++; end
    if (!s_ready) begin s_valid = 1'b0; coef_we = 1'b0; ok = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    s_valid = 1'b0;
    coef_we = cw_busy;
    k = 1;
    while (!m_valid && k < 200) begin @(negedge clk); k++; end
    lat = k;
    if (!m_valid) begin coef_we = 1'b0; ok = 1'b0; return; end
    y = m_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!m_valid || m_data !== y || s_ready) stable = 1'b0;
    end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset s_ready: got %b want 1", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL reset m_data: got %h want 0", m_data); end
    n_cmp++; if (mac_en !== 1'b0) begin n_bad++; $display("FAIL reset mac_en: got %b want 0", mac_en); end
    n_cmp++; if (mac_a !== '0 || mac_b !== '0) begin n_bad++; $display("FAIL reset mac_ab: got %h/%h want 0/0", mac_a, mac_b); end
    n_cmp++; if (mac_acc_in !== '0) begin n_bad++; $display("FAIL reset mac_acc_in: got %h want 0", mac_acc_in); end
  endtask

  task automatic test_impulse();
    logic [AW-1:0] y, e; int lat, ac; bit st, ok;
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(k, DW'(k + 1));
    for (int i = 0; i < NTAPS; i++) begin
      e = ref_push((i == 0) ? DW'(100) : DW'(0));
      send((i == 0) ? DW'(100) : DW'(0), 0, 1'b0, 0, '0, 1'b0, y, lat, ac, st, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL impulse[%0d] timeout: got none want result", i); end
      n_cmp++; if (y !== AW'(100 * (i + 1))) begin n_bad++; $display("FAIL impulse[%0d] data: got %0d want %0d", i, y, 100 * (i + 1)); end
      n_cmp++; if (y !== e) begin n_bad++; $display("FAIL impulse[%0d] model: got %h want %h", i, y, e); end
      n_cmp++; if (lat != NTAPS + 2) begin n_bad++; $display("FAIL impulse[%0d] latency: got %0d want %0d", i, lat, NTAPS + 2); end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] y, e; int lat, ac; bit st, ok;
    logic signed [DW-1:0] x;
    x = DW'($urandom);
    e = ref_push(x);
    send(x, 5, 1'b0, 0, '0, 1'b0, y, lat, ac, st, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL backpressure timeout: got none want result"); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL backpressure hold: got unstable want stable/valid/s_ready=0"); end
    n_cmp++; if (y !== e) begin n_bad++; $display("FAIL backpressure data: got %h want %h", y, e); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL backpressure single: got m_valid=%b want 0", m_valid); end
    n_cmp++; if (lat != NTAPS + 2) begin n_bad++; $display("FAIL backpressure latency: got %0d want %0d", lat, NTAPS + 2); end
  endtask

  task automatic test_extreme(input logic signed [DW-1:0] c, input logic signed [DW-1:0] x,
                              input logic [AW-1:0] final_want);
    logic [AW-1:0] y, e; int lat, ac; bit st, ok;
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(k, c);
    for (int i = 0; i < NTAPS; i++) begin
      e = ref_push(x);
      send(x, 0, 1'b0, 0, '0, 1'b0, y, lat, ac, st, ok);
      n_cmp++; if (!ok || y !== e) begin n_bad++; $display("FAIL extreme c=%h x=%h [%0d]: got %h want %h", c, x, i, y, e); end
    end
    n_cmp++; if (y !== final_want) begin n_bad++; $display("FAIL extreme c=%h x=%h final: got %h want %h", c, x, y, final_want); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] y, e; int lat, ac; bit st, ok, seen;
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(k, DW'($urandom));
    e = ref_push(DW'(1234));
    send(DW'(1234), 0, 1'b0, 0, '0, 1'b0, y, lat, ac, st, ok);
    n_cmp++; if (!ok || y !== e) begin n_bad++; $display("FAIL midreset pre: got %h want %h", y, e); end
    s_valid = 1'b1; s_data = DW'(777);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (mac_en !== 1'b1) begin n_bad++; $display("FAIL midreset running: got mac_en=%b want 1", mac_en); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mac_en !== 1'b0) begin n_bad++; $display("FAIL midreset mac_en: got %b want 0", mac_en); end
    rst = 1'b0;
    ref_clear();
    n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL midreset m_data: got %h want 0", m_data); end
    seen = 1'b0;
    for (int i = 0; i < 2 * NTAPS; i++) begin @(negedge clk); if (m_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset m_valid: got 1 want 0"); end
    write_coef(0, DW'(1));
    write_coef(1, DW'(3));
    e = ref_push(DW'(5));
    send(DW'(5), 0, 1'b0, 0, '0, 1'b0, y, lat, ac, st, ok);
    n_cmp++; if (!ok || y !== AW'(5)) begin n_bad++; $display("FAIL midreset post: got %h want 5", y); end
    n_cmp++; if (y !== e) begin n_bad++; $display("FAIL midreset model: got %h want %h", y, e); end
  endtask

  task automatic test_coef_during_run();
    logic [AW-1:0] y, e; int lat, ac; bit st, ok;
    logic signed [DW-1:0] x;
    for (int i = 0; i < 2; i++) begin
      x = DW'($urandom);
      e = ref_push(x);
      send(x, 0, 1'b0, 0, DW'(16'h0010), 1'b1, y, lat, ac, st, ok);
      n_cmp++; if (!ok || y !== e) begin n_bad++; $display("FAIL coefrun[%0d] data: got %h want %h", i, y, e); end
      n_cmp++; if (lat != NTAPS + 2) begin n_bad++; $display("FAIL coefrun[%0d] latency: got %0d want %0d", i, lat, NTAPS + 2); end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] y, e; int lat, ac, ca; bit st, ok, cw;
    logic signed [DW-1:0] x, cd;
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(k, DW'($urandom));
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef(int'($urandom_range(0, NTAPS - 1)), DW'($urandom));
      cw = ($urandom_range(0, 2) == 0);
      ca = int'($urandom_range(0, NTAPS - 1));
      cd = DW'($urandom);
      x  = DW'($urandom);
      if (cw) ref_coef[ca] = cd;
      e = ref_push(x);
      send(x, int'($urandom_range(0, 3)), cw, ca, cd, 1'b0, y, lat, ac, st, ok);
      n_cmp++; if (!ok || y !== e) begin n_bad++; $display("FAIL random[%0d] data: got %h want %h", i, y, e); end
      n_cmp++; if (lat != NTAPS + 2 || !st) begin n_bad++; $display("FAIL random[%0d] latency/hold: got %0d/%b want %0d/1", i, lat, st, NTAPS + 2); end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] y, e; int lat, ac, prev; bit st, ok;
    logic signed [DW-1:0] x;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      x = DW'($urandom);
      e = ref_push(x);
      send(x, 0, 1'b0, 0, '0, 1'b0, y, lat, ac, st, ok);
      n_cmp++; if (!ok || y !== e) begin n_bad++; $display("FAIL b2b[%0d] data: got %h want %h", i, y, e); end
      if (i > 0) begin
        n_cmp++; if (ac - prev != NTAPS + 3) begin n_bad++; $display("FAIL b2b[%0d] period: got %0d want %0d", i, ac - prev, NTAPS + 3); end
      end
      prev = ac;
    end
  endtask

  initial begin
    ref_clear();
    test_reset();
    test_impulse();
    test_backpressure();
    test_extreme(DW'(16'hFFFF), DW'(16'h8000), 32'h0004_0000);
    test_extreme(DW'(16'h7FFF), DW'(16'h7FFF), 32'hFFF8_0008);
    test_reset_mid();
    test_coef_during_run();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
